open_list_sched: RTL and testbench

//  Open-list scheduler for the maze path search. Holds one cost entry per candidate cell and,
//  on request, scans them sequentially to pop the valid entry with the lowest cost.

---
 rtl/maze_pkg.sv | 14 +
 rtl/open_entry_table.sv | 61 ++++++
 rtl/open_list_sched.sv | 155 +++++++++++++++
 tb/tb_open_list_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze path-search datapath.
package maze_pkg;

  localparam int COST_W = 8;
  localparam logic [COST_W-1:0] COST_MAX = '1;

  // Open-list scheduler FSM: wait for a pop, walk every slot, publish the result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/open_entry_table.sv
// Valid/cost storage for the open list: min-update insert, invalidate,
// synchronous clear and one combinational read port for the serial scan.
// Inserts only happen in IDLE and invalidates only in DONE, so the two
// write paths never target the table in the same cycle.
module open_entry_table #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int COST_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              ins_en_i,
  input  logic [IDX_W-1:0]  ins_idx_i,
  input  logic [COST_W-1:0] ins_cost_i,
  input  logic              inv_en_i,
  input  logic [IDX_W-1:0]  inv_idx_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [COST_W-1:0] rd_cost_o,
  output logic [IDX_W:0]    count_o
);

  logic [ENTRIES-1:0] valid_q;
  logic [COST_W-1:0]  cost_q [ENTRIES];
  logic [IDX_W:0]     count_q;

  // Storage update: clear wins, then insert (new slot or keep-the-minimum), then invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cost_q[i] <= '0;
      end
    end else if (clear_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (ins_en_i) begin
      if (!valid_q[ins_idx_i]) begin
        valid_q[ins_idx_i] <= 1'b1;
        cost_q[ins_idx_i]  <= ins_cost_i;
        count_q            <= count_q + 1'b1;
      end else if (ins_cost_i < cost_q[ins_idx_i]) begin
        cost_q[ins_idx_i] <= ins_cost_i;
      end
    end else if (inv_en_i) begin
      valid_q[inv_idx_i] <= 1'b0;
      count_q            <= count_q - 1'b1;
    end
  end

  // Indexed read used by the scan, one slot per cycle.
  always_comb begin
    rd_valid_o = valid_q[rd_idx_i];
    rd_cost_o  = cost_q[rd_idx_i];
  end

  assign count_o = count_q;

endmodule

// File: rtl/open_list_sched.sv
// Open-list scheduler: serial minimum search over the entry table.
// Handshakes: an insert transfers on a rising edge where ins_valid and
// ins_ready are both high (the requester holds ins_valid/ins_idx/ins_cost
// until then); pop_req is a request sampled only in IDLE and answered by a
// single-cycle pop_valid strobe ENTRIES+1 cycles after the accepting edge.
module open_list_sched #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int COST_W  = maze_pkg::COST_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [IDX_W-1:0]     ins_idx,
  input  logic [COST_W-1:0]    ins_cost,
  input  logic                 pop_req,
  output logic                 pop_valid,
  output logic [IDX_W-1:0]     pop_idx,
  output logic [COST_W-1:0]    pop_cost,
  output logic                 pop_empty,
  output logic                 busy,
  output logic [IDX_W:0]       count,
  output maze_pkg::state_e     dbg_state
);

  import maze_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  scan_q;
  logic              found_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [COST_W-1:0] best_cost_q;
  logic              pop_valid_q;
  logic [IDX_W-1:0]  pop_idx_q;
  logic [COST_W-1:0] pop_cost_q;
  logic              pop_empty_q;

  logic              rd_valid;
  logic [COST_W-1:0] rd_cost;
  logic              ins_en;
  logic              inv_en;

  assign ins_en = ins_valid && ins_ready && !clear;
  assign inv_en = (state_q == S_DONE) && found_q && !clear;

  open_entry_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .COST_W  (COST_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .ins_en_i   (ins_en),
    .ins_idx_i  (ins_idx),
    .ins_cost_i (ins_cost),
    .inv_en_i   (inv_en),
    .inv_idx_i  (best_idx_q),
    .rd_idx_i   (scan_q),
    .rd_valid_o (rd_valid),
    .rd_cost_o  (rd_cost),
    .count_o    (count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/status outputs; clear forces IDLE from any state.
  always_comb begin
    state_d   = state_q;
    ins_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ins_ready = 1'b1;
        if (pop_req) state_d = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (scan_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // Scan datapath: track the first strictly-smaller valid cost, then register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q      <= '0;
      found_q     <= 1'b0;
      best_idx_q  <= '0;
      best_cost_q <= '0;
      pop_valid_q <= 1'b0;
      pop_idx_q   <= '0;
      pop_cost_q  <= '0;
      pop_empty_q <= 1'b0;
    end else begin
      pop_valid_q <= 1'b0;
      if (clear) begin
        scan_q  <= '0;
        found_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pop_req) begin
              scan_q      <= '0;
              found_q     <= 1'b0;
              best_idx_q  <= '0;
              best_cost_q <= '1;
            end
          end
          S_SCAN: begin
            scan_q <= scan_q + 1'b1;
            if (rd_valid && (!found_q || rd_cost < best_cost_q)) begin
              found_q     <= 1'b1;
              best_idx_q  <= scan_q;
              best_cost_q <= rd_cost;
            end
          end
          S_DONE: begin
            pop_valid_q <= 1'b1;
            pop_empty_q <= !found_q;
            pop_idx_q   <= found_q ? best_idx_q : '0;
            pop_cost_q  <= found_q ? best_cost_q : '1;
          end
          default: begin
            scan_q <= '0;
          end
        endcase
      end
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_idx   = pop_idx_q;
  assign pop_cost  = pop_cost_q;
  assign pop_empty = pop_empty_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_open_list_sched.sv
// Randomised and directed bench for open_list_sched with a queue scoreboard.
module tb_open_list_sched;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int COST_W  = 8;
  localparam int EXP_W   = 32 + (IDX_W + 1) + 1 + IDX_W + COST_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              ins_valid = 1'b0;
  logic              ins_ready;
  logic [IDX_W-1:0]  ins_idx = '0;
  logic [COST_W-1:0] ins_cost = '0;
  logic              pop_req = 1'b0;
  logic              pop_valid;
  logic [IDX_W-1:0]  pop_idx;
  logic [COST_W-1:0] pop_cost;
  logic              pop_empty;
  logic              busy;
  logic [IDX_W:0]    count;
  maze_pkg::state_e  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: plain arrays of the open list contents.
  bit m_valid [ENTRIES];
  int m_cost  [ENTRIES];
  int m_cnt;

  logic [EXP_W-1:0] exp_q[$];

  open_list_sched #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .COST_W  (COST_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_idx   (ins_idx),
    .ins_cost  (ins_cost),
    .pop_req   (pop_req),
    .pop_valid (pop_valid),
    .pop_idx   (pop_idx),
    .pop_cost  (pop_cost),
    .pop_empty (pop_empty),
    .busy      (busy),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cost[i]  = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_insert(input int idx, input int cost);
    if (!m_valid[idx]) begin
      m_valid[idx] = 1'b1;
      m_cost[idx]  = cost;
      m_cnt++;
    end else if (cost < m_cost[idx]) begin
      m_cost[idx] = cost;
    end
  endfunction

  // Lowest cost among valid slots; among equal costs the lowest index wins.
  function automatic void push_expect(input int c0);
    int minc = 1 << COST_W;
    int best = -1;
    logic [EXP_W-1:0] e;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_cost[i] < minc) minc = m_cost[i];
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (m_valid[i] && m_cost[i] == minc) best = i;
    if (best < 0) begin
      e = {32'(c0 + ENTRIES + 1), (IDX_W+1)'(m_cnt), 1'b1, IDX_W'(0), maze_pkg::COST_MAX};
    end else begin
      m_valid[best] = 1'b0;
      m_cnt--;
      e = {32'(c0 + ENTRIES + 1), (IDX_W+1)'(m_cnt), 1'b0, IDX_W'(best), COST_W'(minc)};
    end
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && pop_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_valid", 1, 0);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("pop_latency_cycle", cyc, e[EXP_W-1 -: 32]);
        check("count_after_pop", count, e[EXP_W-33 -: (IDX_W+1)]);
        check("pop_empty", pop_empty, e[IDX_W+COST_W]);
        check("pop_idx", pop_idx, e[IDX_W+COST_W-1 -: IDX_W]);
        check("pop_cost", pop_cost, e[COST_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_insert(input int idx, input int cost);
    bit acc = 1'b0;
    int guard = 0;
    @(negedge clk);
    ins_valid = 1'b1;
    ins_idx   = IDX_W'(idx);
    ins_cost  = COST_W'(cost);
    while (!acc && guard < 100) begin
      acc = ins_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    ins_valid = 1'b0;
    if (!acc) begin
      check("insert_accept_timeout", 0, 1);
    end else begin
      model_insert(idx, cost);
      check("count_after_insert", count, m_cnt);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!ins_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ins_ready) check("idle_wait_timeout", 0, 1);
  endtask

  // Issue one pop; when abort is set the caller kills it, so nothing is expected.
  task automatic do_pop(input bit abort);
    int c0;
    wait_idle();
    pop_req = 1'b1;
    @(posedge clk);
    #1;
    pop_req = 1'b0;
    c0 = cyc;
    if (!abort) begin
      push_expect(c0);
      repeat (ENTRIES + 2) @(posedge clk);
      #2;
      check("pop_drained", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Insert and pop requested in the same IDLE cycle; also counts ins_ready-low cycles.
  task automatic do_ins_pop(input int idx, input int cost);
    int c0;
    int lows = 0;
    wait_idle();
    ins_valid = 1'b1;
    ins_idx   = IDX_W'(idx);
    ins_cost  = COST_W'(cost);
    pop_req   = 1'b1;
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    pop_req   = 1'b0;
    c0 = cyc;
    model_insert(idx, cost);
    push_expect(c0);
    for (int i = 0; i < ENTRIES + 1; i++) begin
      @(negedge clk);
      if (!ins_ready && busy) lows++;
    end
    check("ins_ready_low_cycles", lows, ENTRIES + 1);
    @(negedge clk);
    check("ins_ready_back_high", ins_ready, 1);
    #2;
    check("pop_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle_empty(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ins_ready"}, ins_ready, 1);
    check({tag, "_count"}, count, 0);
    check({tag, "_state"}, dbg_state, maze_pkg::S_IDLE);
    check({tag, "_pop_valid"}, pop_valid, 0);
  endtask

  task automatic fill_four();
    do_insert(1, 50);
    do_insert(4, 30);
    do_insert(8, 70);
    do_insert(12, 30);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ins_ready", ins_ready, 1);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_pop_idx", pop_idx, 0);
    check("rst_pop_cost", pop_cost, 0);
    check("rst_pop_empty", pop_empty, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;

    // Empty pop.
    do_pop(1'b0);

    // Basic minimum, then second pop.
    do_insert(3, 40);
    do_insert(7, 12);
    do_insert(9, 90);
    do_pop(1'b0);
    do_pop(1'b0);
    do_pop(1'b0);
    do_pop(1'b0);

    // Tie goes to lowest index; updates keep the minimum.
    do_insert(5, 20);
    do_insert(2, 20);
    do_pop(1'b0);
    do_insert(5, 10);
    do_insert(5, 30);
    do_pop(1'b0);

    // Same-cycle insert and pop.
    do_ins_pop(0, 1);

    // Insert request held while busy is accepted once IDLE returns.
    do_insert(6, 77);
    fork
      do_pop(1'b0);
      begin
        repeat (3) @(posedge clk);
        do_insert(11, 5);
      end
    join
    do_pop(1'b0);

    // Clear mid-scan.
    fill_four();
    do_pop(1'b1);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check_idle_empty("clear");
    repeat (ENTRIES + 4) @(negedge clk);
    check("clear_count_later", count, 0);
    do_pop(1'b0);

    // Reset mid-scan.
    fill_four();
    do_pop(1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_empty("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ENTRIES + 4) @(negedge clk);
    check("reset_count_later", count, 0);
    do_pop(1'b0);

    // Randomised inserts and pops against the model.
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        do_insert($urandom_range(0, ENTRIES - 1), $urandom_range(0, (1 << COST_W) - 1));
      end else if (sel < 8) begin
        do_pop(1'b0);
      end else if (sel == 8) begin
        do_ins_pop($urandom_range(0, ENTRIES - 1), $urandom_range(0, (1 << COST_W) - 1));
      end else begin
        do_insert($urandom_range(0, ENTRIES - 1), $urandom_range(250, (1 << COST_W) - 1));
      end
    end
    while (m_cnt > 0) do_pop(1'b0);
    do_pop(1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
